// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU: operation codes and FSM states.
package seq_alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_RUN  = 2'b01;
   localparam logic [1:0] ST_DONE = 2'b10;

   typedef logic [1:0] op_t;

endpackage

// File: rtl/seq_alu_div_step.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder and subtract the divisor when it fits.
module div_step
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic             bit_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic             q_bit
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] divisor_ext;

   // rem_in < divisor holds on entry, so the restored remainder fits in WIDTH bits
   always_comb begin
      shifted     = {rem_in, bit_in};
      divisor_ext = {1'b0, divisor};
      q_bit       = (shifted >= divisor_ext);
      rem_out     = WIDTH'(q_bit ? (shifted - divisor_ext) : shifted);
   end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle unsigned ADD/SUB/MUL/DIV with start/done handshake; MUL is
// shift-add and DIV restoring, both one bit per RUN cycle.
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             carry_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             carry_out,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);

   logic [1:0]       state;
   op_t              op_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             cin_q;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] work_hi;
   logic [WIDTH-1:0] work_lo;

   logic [WIDTH:0]   add_sum;
   logic [WIDTH-1:0] sub_diff;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mul_hi_n;
   logic [WIDTH-1:0] mul_lo_n;
   logic [WIDTH-1:0] div_rem;
   logic             div_q;
   logic [WIDTH-1:0] div_lo_n;

   // work_hi/work_lo hold {product} for MUL and {remainder, dividend->quotient} for DIV
   div_step #(.WIDTH(WIDTH)) u_div_step (
      .rem_in  (work_hi),
      .bit_in  (work_lo[WIDTH-1]),
      .divisor (b_q),
      .rem_out (div_rem),
      .q_bit   (div_q)
   );

   always_comb begin
      add_sum  = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
      sub_diff = a_q - b_q;
      mul_sum  = {1'b0, work_hi} + (work_lo[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
      mul_hi_n = mul_sum[WIDTH:1];
      mul_lo_n = {mul_sum[0], work_lo[WIDTH-1:1]};
      div_lo_n = {work_lo[WIDTH-2:0], div_q};
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         op_q      <= OP_ADD;
         a_q       <= '0;
         b_q       <= '0;
         cin_q     <= 1'b0;
         cnt       <= '0;
         work_hi   <= '0;
         work_lo   <= '0;
         result_lo <= '0;
         result_hi <= '0;
         carry_out <= 1'b0;
         err       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  op_q    <= op;
                  a_q     <= a;
                  b_q     <= b;
                  cin_q   <= carry_in;
                  err     <= 1'b0;
                  cnt     <= op[1] ? CNT_INIT : '0;
                  work_hi <= '0;
                  work_lo <= (op == OP_MUL) ? b : a;
                  state   <= ST_RUN;
               end
            end
            ST_RUN: begin
               case (op_q)
                  OP_ADD: begin
                     {carry_out, result_lo} <= add_sum;
                     result_hi <= '0;
                     state     <= ST_DONE;
                  end
                  OP_SUB: begin
                     result_lo <= sub_diff;
                     result_hi <= '0;
                     carry_out <= (a_q < b_q);
                     state     <= ST_DONE;
                  end
                  OP_MUL: begin
                     work_hi <= mul_hi_n;
                     work_lo <= mul_lo_n;
                     if (cnt == '0) begin
                        result_hi <= mul_hi_n;
                        result_lo <= mul_lo_n;
                        carry_out <= 1'b0;
                        state     <= ST_DONE;
                     end else begin
                        cnt <= cnt - CNT_W'(1);
                     end
                  end
                  default: begin
                     if (b_q == '0) begin
                        err       <= 1'b1;
                        result_lo <= '0;
                        result_hi <= a_q;
                        carry_out <= 1'b0;
                        cnt       <= '0;
                        state     <= ST_DONE;
                     end else begin
                        work_hi <= div_rem;
                        work_lo <= div_lo_n;
                        if (cnt == '0) begin
                           result_hi <= div_rem;
                           result_lo <= div_lo_n;
                           carry_out <= 1'b0;
                           state     <= ST_DONE;
                        end else begin
                           cnt <= cnt - CNT_W'(1);
                        end
                     end
                  end
               endcase
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: directed and random operations at WIDTH 4, 8 and 16,
// checked against an arithmetic reference model.
module tb_seq_alu;

   localparam logic [1:0] ADD = 2'b00;
   localparam logic [1:0] SUB = 2'b01;
   localparam logic [1:0] MUL = 2'b10;
   localparam logic [1:0] DIV = 2'b11;

   localparam int F_LO = 0, F_HI = 1, F_CO = 2, F_ERR = 3, F_DONE = 4, F_BUSY = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  op;
   logic [15:0] a_bus, b_bus;
   logic        cin;
   logic        start4, start8, start16;

   logic        busy4, done4, co4, err4;
   logic [3:0]  lo4, hi4;
   logic        busy8, done8, co8, err8;
   logic [7:0]  lo8, hi8;
   logic        busy16, done16, co16, err16;
   logic [15:0] lo16, hi16;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_alu #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .op(op), .a(a_bus[7:0]), .b(b_bus[7:0]),
      .carry_in(cin), .busy(busy8), .done(done8), .result_lo(lo8), .result_hi(hi8),
      .carry_out(co8), .err(err8));

   seq_alu #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .start(start4), .op(op), .a(a_bus[3:0]), .b(b_bus[3:0]),
      .carry_in(cin), .busy(busy4), .done(done4), .result_lo(lo4), .result_hi(hi4),
      .carry_out(co4), .err(err4));

   seq_alu #(.WIDTH(16)) dut16 (
      .clk(clk), .rst(rst), .start(start16), .op(op), .a(a_bus), .b(b_bus),
      .carry_in(cin), .busy(busy16), .done(done16), .result_lo(lo16), .result_hi(hi16),
      .carry_out(co16), .err(err16));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] probe(input int w, input int f);
      logic [63:0] v;
      v = '0;
      case (w)
         4: case (f)
               F_LO: v = {60'd0, lo4};   F_HI: v = {60'd0, hi4};
               F_CO: v = {63'd0, co4};   F_ERR: v = {63'd0, err4};
               F_DONE: v = {63'd0, done4}; default: v = {63'd0, busy4};
            endcase
         16: case (f)
               F_LO: v = {48'd0, lo16};  F_HI: v = {48'd0, hi16};
               F_CO: v = {63'd0, co16};  F_ERR: v = {63'd0, err16};
               F_DONE: v = {63'd0, done16}; default: v = {63'd0, busy16};
            endcase
         default: case (f)
               F_LO: v = {56'd0, lo8};   F_HI: v = {56'd0, hi8};
               F_CO: v = {63'd0, co8};   F_ERR: v = {63'd0, err8};
               F_DONE: v = {63'd0, done8}; default: v = {63'd0, busy8};
            endcase
      endcase
      return v;
   endfunction

   task automatic set_start(input int w, input logic v);
      start4  = (w == 4)  && v;
      start8  = (w == 8)  && v;
      start16 = (w == 16) && v;
   endtask

   // Reference: plain unsigned arithmetic on the operand values
   task automatic model(input int w, input logic [1:0] o, input longint unsigned ua,
                        input longint unsigned ub, input bit ci,
                        output longint unsigned lo, output longint unsigned hi,
                        output bit co, output bit er, output int lat);
      longint unsigned mask, s;
      mask = (64'd1 << w) - 1;
      lo = 0; hi = 0; co = 0; er = 0; lat = 2;
      case (o)
         ADD: begin s = ua + ub + ci; lo = s & mask; co = ((s >> w) & 1) != 0; end
         SUB: begin lo = (ua - ub) & mask; co = (ua < ub); end
         MUL: begin s = ua * ub; lo = s & mask; hi = s >> w; lat = w + 1; end
         default: begin
            if (ub == 0) begin er = 1; hi = ua; end
            else begin lo = ua / ub; hi = ua % ub; lat = w + 1; end
         end
      endcase
   endtask

   task automatic run(input int w, input logic [1:0] o, input logic [15:0] av,
                      input logic [15:0] bv, input bit ci, input string tag, input int inject);
      longint unsigned e_lo, e_hi, mask;
      bit e_co, e_er;
      int e_lat, cyc;
      mask = (64'd1 << w) - 1;
      model(w, o, av & mask, bv & mask, ci, e_lo, e_hi, e_co, e_er, e_lat);
      @(negedge clk);
      op = o; a_bus = av; b_bus = bv; cin = ci;
      set_start(w, 1'b1);
      @(negedge clk);
      set_start(w, 1'b0);
      a_bus = 16'($urandom); b_bus = 16'($urandom); op = 2'($urandom); cin = 1'($urandom);
      cyc = 1;
      chk({tag, "/busy"}, probe(w, F_BUSY), 64'd1);
      while (probe(w, F_DONE) != 64'd1 && cyc < 100) begin
         if (cyc == inject) begin set_start(w, 1'b1); op = ADD; end
         else set_start(w, 1'b0);
         @(negedge clk);
         cyc++;
      end
      set_start(w, 1'b0);
      chk({tag, "/latency"}, 64'(cyc), 64'(e_lat));
      chk({tag, "/lo"}, probe(w, F_LO), e_lo);
      chk({tag, "/hi"}, probe(w, F_HI), e_hi);
      chk({tag, "/carry"}, probe(w, F_CO), {63'd0, e_co});
      chk({tag, "/err"}, probe(w, F_ERR), {63'd0, e_er});
      @(negedge clk);
      chk({tag, "/done_pulse"}, probe(w, F_DONE), 64'd0);
      chk({tag, "/idle"}, probe(w, F_BUSY), 64'd0);
      chk({tag, "/hold_lo"}, probe(w, F_LO), e_lo);
      chk({tag, "/hold_err"}, probe(w, F_ERR), {63'd0, e_er});
   endtask

   initial begin
      int n_done;
      rst = 1'b1; op = ADD; a_bus = '0; b_bus = '0; cin = 1'b0;
      set_start(8, 1'b0);
      repeat (3) @(negedge clk);
      chk("reset/busy", probe(8, F_BUSY), 64'd0);
      chk("reset/done", probe(8, F_DONE), 64'd0);
      chk("reset/lo", probe(8, F_LO), 64'd0);
      chk("reset/hi", probe(8, F_HI), 64'd0);
      chk("reset/carry", probe(8, F_CO), 64'd0);
      chk("reset/err", probe(8, F_ERR), 64'd0);
      rst = 1'b0;

      run(8, ADD, 16'd200, 16'd100, 1'b1, "add200_100", -1);
      run(8, SUB, 16'd5, 16'd9, 1'b0, "sub5_9", -1);
      run(8, MUL, 16'd255, 16'd255, 1'b0, "mul255_255", -1);
      run(8, MUL, 16'd0, 16'd77, 1'b0, "mul0_77", -1);
      run(8, DIV, 16'd200, 16'd7, 1'b0, "div200_7", -1);
      run(8, DIV, 16'd3, 16'd10, 1'b0, "div3_10", -1);
      run(8, DIV, 16'd0, 16'd5, 1'b0, "div0_5", -1);
      run(8, DIV, 16'd42, 16'd0, 1'b0, "div42_0", -1);
      run(8, ADD, 16'd1, 16'd1, 1'b0, "add1_1", -1);
      run(8, MUL, 16'd13, 16'd11, 1'b0, "mul_inject", 3);

      // Reset in the middle of a DIV aborts it without a done pulse
      @(negedge clk);
      op = DIV; a_bus = 16'd200; b_bus = 16'd7; set_start(8, 1'b1);
      @(negedge clk);
      set_start(8, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid/busy", probe(8, F_BUSY), 64'd0);
      chk("rst_mid/done", probe(8, F_DONE), 64'd0);
      chk("rst_mid/lo", probe(8, F_LO), 64'd0);
      chk("rst_mid/hi", probe(8, F_HI), 64'd0);
      chk("rst_mid/carry", probe(8, F_CO), 64'd0);
      chk("rst_mid/err", probe(8, F_ERR), 64'd0);
      n_done = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (probe(8, F_DONE) == 64'd1) n_done++;
      end
      chk("rst_mid/no_done", 64'(n_done), 64'd0);
      run(8, DIV, 16'd250, 16'd9, 1'b0, "after_rst_div", -1);

      for (int i = 0; i < 40; i++) begin
         logic [15:0] rb;
         rb = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
         run(8, 2'($urandom), 16'($urandom), rb, 1'($urandom), $sformatf("rand8_%0d", i), -1);
      end

      run(4, MUL, 16'd15, 16'd15, 1'b0, "w4_mul15_15", -1);
      run(4, DIV, 16'd15, 16'd4, 1'b0, "w4_div15_4", -1);
      run(4, ADD, 16'd9, 16'd8, 1'b1, "w4_add", -1);
      run(16, DIV, 16'd65535, 16'd255, 1'b0, "w16_div", -1);
      run(16, MUL, 16'd65535, 16'd65535, 1'b0, "w16_mul", -1);
      run(16, SUB, 16'd3, 16'd40000, 1'b0, "w16_sub", -1);
      for (int i = 0; i < 8; i++) begin
         run(4, 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rand4_%0d", i), -1);
         run(16, 2'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), $sformatf("rand16_%0d", i), -1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
